mpmc11_chan_arbiter_fta: RTL and testbench



---
 rtl/fta_bus_pkg.sv | 14 +
 rtl/mpmc11_pkg.sv | 13 +
 rtl/mpmc11_rr_pick.sv | 32 +++
 rtl/mpmc11_chan_arbiter_fta.sv | 136 +++++++++++++
 tb/tb_mpmc11_chan_arbiter_fta.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: command request type passed from the channel queues to the memory controller.
`default_nettype none
package fta_bus_pkg;

  typedef struct packed {
    logic [3:0]   cmd;
    logic [7:0]   tid;
    logic [31:0]  padr;
    logic [31:0]  sel;
    logic [255:0] data;
  } fta_cmd_request256_t;

endpackage
`default_nettype wire

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared types and constants for the mpmc11 memory controller front end.
`default_nettype none
package mpmc11_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } mpmc11_arb_state_t;

  localparam int MPMC11_TO_LIM = 1023;

endpackage
`default_nettype wire

// File: rtl/mpmc11_rr_pick.sv
// mpmc11_rr_pick: combinational round-robin finder; first set req_v bit above `last`, wrapping.
`default_nettype none
module mpmc11_rr_pick #(
  parameter int NCH = 8
) (
  input  logic [NCH-1:0]         req_v,
  input  logic [$clog2(NCH)-1:0] last,
  output logic [$clog2(NCH)-1:0] w,
  output logic                   any
);

  localparam int LW = $clog2(NCH);

  int            idx;
  logic [LW-1:0] sel;

  // Scan from farthest to nearest so the nearest requester overwrites earlier hits.
  always_comb begin
    w   = '0;
    any = |req_v;
    idx = 0;
    sel = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NCH) idx = idx - NCH;
      sel = idx[LW-1:0];
      if (req_v[sel]) w = sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpmc11_chan_arbiter_fta.sv
// mpmc11_chan_arbiter_fta: channel arbiter, command holding register and transaction watchdog.
// Optional MPMC11_CH0_PRIO_EN gives channel 0 absolute priority without disturbing round-robin order.
`default_nettype none
module mpmc11_chan_arbiter_fta
  import fta_bus_pkg::*;
  import mpmc11_pkg::*;
#(
  parameter int NCH    = 8,
  parameter int TO_LIM = MPMC11_TO_LIM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   calib_complete,
  input  logic [NCH-1:0]         req_v,
  input  fta_cmd_request256_t    req [NCH],
  output logic [NCH-1:0]         req_ack,
  input  logic                   done,
  output fta_cmd_request256_t    fifo_out,
  output logic                   fifo_v,
  output logic [$clog2(NCH)-1:0] ch,
  output logic                   to,
  output logic                   to_err,
  output logic [$clog2(NCH)-1:0] to_ch
);

  localparam int         LW  = $clog2(NCH);
  localparam logic [9:0] LIM = 10'(TO_LIM);

  mpmc11_arb_state_t   state_q, state_d;
  fta_cmd_request256_t fifo_out_q, fifo_out_d;
  logic                fifo_v_q, fifo_v_d;
  logic [LW-1:0]       ch_q, ch_d;
  logic [NCH-1:0]      req_ack_q, req_ack_d;
  logic [LW-1:0]       last_q, last_d;
  logic [9:0]          wdog_q, wdog_d;
  logic                to_q, to_d;
  logic                to_err_q, to_err_d;
  logic [LW-1:0]       to_ch_q, to_ch_d;

  logic [LW-1:0]       rr_w;
  logic                rr_any;
  logic [LW-1:0]       win;
  logic                upd_last;

  mpmc11_rr_pick #(.NCH(NCH)) u_pick (
    .req_v (req_v),
    .last  (last_q),
    .w     (rr_w),
    .any   (rr_any)
  );

`ifdef MPMC11_CH0_PRIO_EN
  assign win      = req_v[0] ? '0 : rr_w;
  assign upd_last = !req_v[0];
`else
  assign win      = rr_w;
  assign upd_last = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    fifo_out_d = fifo_out_q;
    fifo_v_d   = fifo_v_q;
    ch_d       = ch_q;
    req_ack_d  = '0;
    last_d     = last_q;
    wdog_d     = wdog_q;
    to_d       = 1'b0;
    to_err_d   = to_err_q;
    to_ch_d    = to_ch_q;
    case (state_q)
      ARB_IDLE: begin
        if (calib_complete && rr_any) begin
          fifo_out_d = req[win];
          ch_d       = win;
          fifo_v_d   = 1'b1;
          req_ack_d  = {{(NCH-1){1'b0}}, 1'b1} << win;
          if (upd_last) last_d = win;
          wdog_d     = '0;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        wdog_d = wdog_q + 10'd1;
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (done) begin
          fifo_v_d = 1'b0;
          state_d  = ARB_IDLE;
        end else if (wdog_q == LIM) begin
          to_d     = 1'b1;
          to_err_d = 1'b1;
          to_ch_d  = ch_q;
          fifo_v_d = 1'b0;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      fifo_out_q <= '0;
      fifo_v_q   <= 1'b0;
      ch_q       <= '0;
      req_ack_q  <= '0;
      last_q     <= LW'(NCH - 1);
      wdog_q     <= '0;
      to_q       <= 1'b0;
      to_err_q   <= 1'b0;
      to_ch_q    <= '0;
    end else begin
      state_q    <= state_d;
      fifo_out_q <= fifo_out_d;
      fifo_v_q   <= fifo_v_d;
      ch_q       <= ch_d;
      req_ack_q  <= req_ack_d;
      last_q     <= last_d;
      wdog_q     <= wdog_d;
      to_q       <= to_d;
      to_err_q   <= to_err_d;
      to_ch_q    <= to_ch_d;
    end
  end

  assign fifo_out = fifo_out_q;
  assign fifo_v   = fifo_v_q;
  assign ch       = ch_q;
  assign req_ack  = req_ack_q;
  assign to       = to_q;
  assign to_err   = to_err_q;
  assign to_ch    = to_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_mpmc11_chan_arbiter_fta.sv
// tb_mpmc11_chan_arbiter_fta: directed vectors and corner-case sequences for the channel arbiter.
`default_nettype none
module tb_mpmc11_chan_arbiter_fta;
  import fta_bus_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                calib_complete = 1'b0;
  logic [7:0]          req_v = 8'h00;
  fta_cmd_request256_t req [8];
  logic [7:0]          req_ack;
  logic                done = 1'b0;
  fta_cmd_request256_t fifo_out;
  logic                fifo_v;
  logic [2:0]          ch;
  logic                to;
  logic                to_err;
  logic [2:0]          to_ch;

  int n_pass = 0;
  int n_total = 0;

  mpmc11_chan_arbiter_fta #(.NCH(8), .TO_LIM(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .calib_complete (calib_complete),
    .req_v          (req_v),
    .req            (req),
    .req_ack        (req_ack),
    .done           (done),
    .fifo_out       (fifo_out),
    .fifo_v         (fifo_v),
    .ch             (ch),
    .to             (to),
    .to_err         (to_err),
    .to_ch          (to_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       cal;
    logic [7:0] rv;
    logic       dn;
    logic       ev;
    logic [7:0] eack;
    logic [2:0] ech;
  } vec_t;

  vec_t tbl [10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One full transaction: grant, two held cycles with done in the second, then one idle cycle.
  task automatic grant_cycle(input int exp_ch);
    tick;
    chk("grant_v", 32'(fifo_v), 32'd1);
    chk("grant_ack", 32'(req_ack), 32'(8'h01 << exp_ch));
    chk("grant_ch", 32'(ch), 32'(exp_ch));
    chk("grant_tid", 32'(fifo_out.tid), 32'(exp_ch));
    tick;
    chk("hold_v", 32'(fifo_v), 32'd1);
    chk("hold_ack", 32'(req_ack), 32'd0);
    tick;
    chk("hold2_v", 32'(fifo_v), 32'd1);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("gap_v", 32'(fifo_v), 32'd0);
    chk("gap_ack", 32'(req_ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      req[i].cmd  = 4'h1;
      req[i].tid  = 8'(i);
      req[i].padr = 32'h1000_0000 + 32'(i);
      req[i].sel  = 32'hFFFF_FFFF;
      req[i].data = {8{32'hC0DE_0000 + 32'(i)}};
    end

    tbl[0] = '{1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1] = '{1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 8'h01, 3'd0};
    tbl[2] = '{1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 8'h00, 3'd0};
    tbl[3] = '{1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[4] = '{1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 3'd7};
    tbl[5] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd7};
    tbl[6] = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 3'd7};
    tbl[7] = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 3'd7};
    tbl[8] = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 8'h04, 3'd2};
    tbl[9] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd2};

    for (int i = 0; i < 10; i++) begin
      rst_n          = tbl[i].rst_n;
      calib_complete = tbl[i].cal;
      req_v          = tbl[i].rv;
      done           = tbl[i].dn;
      tick;
      chk($sformatf("vec%0d_v", i), 32'(fifo_v), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_ack", i), 32'(req_ack), 32'(tbl[i].eack));
      chk($sformatf("vec%0d_ch", i), 32'(ch), 32'(tbl[i].ech));
      chk($sformatf("vec%0d_to", i), 32'(to), 32'd0);
      if (tbl[i].ev) chk($sformatf("vec%0d_tid", i), 32'(fifo_out.tid), 32'(tbl[i].ech));
    end
    done = 1'b0;

`ifndef MPMC11_CH0_PRIO_EN
    // All channels requesting: strict rotation starting from channel 0.
    rst_n = 1'b0; req_v = 8'h00;
    tick;
    rst_n = 1'b1; calib_complete = 1'b1; req_v = 8'hFF;
    for (int g = 0; g < 9; g++) grant_cycle(g % 8);
`else
    // Channel 0 wins whenever it requests; rotation then continues from channel 1.
    rst_n = 1'b0; req_v = 8'h00;
    tick;
    rst_n = 1'b1; calib_complete = 1'b1; req_v = 8'hFF;
    for (int g = 0; g < 3; g++) grant_cycle(0);
    req_v = 8'hFE;
    for (int g = 1; g < 4; g++) grant_cycle(g);
`endif

    // Watchdog expiry on channel 5.
    rst_n = 1'b0; req_v = 8'h00;
    tick;
    rst_n = 1'b1; req_v = 8'h20;
    tick;
    chk("to_grant_ch", 32'(ch), 32'd5);
    chk("to_grant_ack", 32'(req_ack), 32'h20);
    req_v = 8'h00;
    for (int k = 1; k <= 15; k++) begin
      tick;
      chk("to_early", 32'(to), 32'd0);
      chk("to_early_v", 32'(fifo_v), 32'd1);
    end
    tick;
    chk("to_pulse", 32'(to), 32'd1);
    chk("to_err_set", 32'(to_err), 32'd1);
    chk("to_ch", 32'(to_ch), 32'd5);
    chk("to_v_drop", 32'(fifo_v), 32'd0);
    req_v = 8'hFE;
    tick;
    chk("to_next_ch", 32'(ch), 32'd6);
    chk("to_next_ack", 32'(req_ack), 32'h40);
    chk("to_one_shot", 32'(to), 32'd0);
    chk("to_err_sticky", 32'(to_err), 32'd1);
    req_v = 8'h00;
    tick;
    tick;

    // Reset while BUSY with a recorded time-out.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("rst_v", 32'(fifo_v), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_to", 32'(to), 32'd0);
    chk("rst_to_err", 32'(to_err), 32'd0);
    chk("rst_to_ch", 32'(to_ch), 32'd0);
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_fifo_out", 32'(fifo_out == '0), 32'd1);

    // done coincides with watchdog expiry: no time-out recorded.
    req_v = 8'hFF;
    tick;
    chk("co_grant_ch", 32'(ch), 32'd0);
    req_v = 8'h00;
    for (int k = 1; k <= 15; k++) tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("co_v", 32'(fifo_v), 32'd0);
    chk("co_to", 32'(to), 32'd0);
    chk("co_to_err", 32'(to_err), 32'd0);
    tick;
    chk("co_to_after", 32'(to), 32'd0);
    chk("co_to_err_after", 32'(to_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
